// File: rtl/acr_packet_generator_if.sv
// Audio strobe / rate inputs and ACR packet outputs of acr_packet_generator.
// master = generator side, slave = scheduler/source side.
interface acr_packet_generator_if;
   logic             audio_strobe;
   logic [2:0]       rate_sel;
   logic             packet_ready;
   logic             packet_valid;
   logic [23:0]      header;
   logic [3:0][55:0] sub;
   logic [19:0]      cts;
   logic             cts_locked;
   logic             audio_lost;

   modport master (
      input  audio_strobe, rate_sel, packet_ready,
      output packet_valid, header, sub, cts, cts_locked, audio_lost
   );

   modport slave (
      output audio_strobe, rate_sel, packet_ready,
      input  packet_valid, header, sub, cts, cts_locked, audio_lost
   );
endinterface

// File: rtl/acr_packet_generator.sv
// Measures clk_pixel cycles per N/128 audio strobes (CTS) and publishes an
// ACR packet at every window boundary, with CTS lock and audio-loss tracking.
module acr_packet_generator #(
   parameter int CTS_TOL        = 2,
   parameter int LOCK_COUNT     = 4,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                   clk_pixel,
   input  logic                   reset,
   acr_packet_generator_if.master acr
);
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int ST_W = $clog2(LOCK_COUNT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ST_W-1:0] ST_MAX  = ST_W'(LOCK_COUNT);
   localparam logic [19:0]     TOL     = 20'(CTS_TOL);

   typedef enum logic [1:0] {SYNC, MEASURE, LOST} state_t;

   state_t          state_reg, state_next;
   logic [2:0]      rate_reg, rate_next;
   logic [7:0]      strobe_cnt_reg, strobe_cnt_next;
   logic [19:0]     cycle_cnt_reg, cycle_cnt_next;
   logic [TO_W-1:0] timeout_cnt_reg, timeout_cnt_next;
   logic [ST_W-1:0] stable_cnt_reg, stable_cnt_next;
   logic [19:0]     cts_reg, cts_next;
   logic [19:0]     n_pkt_reg, n_pkt_next;
   logic            valid_reg, valid_next;
   logic            lost_reg, lost_next;

   logic [19:0]      n_cur;
   logic [7:0]       w_cur;
   logic [19:0]      cycle_inc;
   logic [19:0]      cts_diff;
   logic             rate_ok;
   logic             timeout_hit;
   logic [3:0][55:0] sub_w;

   always_comb begin
      case (rate_reg)
         3'd0:    n_cur = 20'd4096;
         3'd1:    n_cur = 20'd6272;
         3'd2:    n_cur = 20'd6144;
         3'd3:    n_cur = 20'd12544;
         3'd4:    n_cur = 20'd12288;
         3'd5:    n_cur = 20'd25088;
         3'd6:    n_cur = 20'd24576;
         default: n_cur = 20'd0;
      endcase
   end

   assign w_cur       = n_cur[14:7];
   assign rate_ok     = (rate_reg != 3'd7);
   // This cycle is counted too, so a boundary publishes cycle_inc rather than cycle_cnt_reg.
   assign cycle_inc   = (cycle_cnt_reg == 20'hFFFFF) ? 20'hFFFFF : cycle_cnt_reg + 20'd1;
   assign cts_diff    = (cycle_inc >= cts_reg) ? cycle_inc - cts_reg : cts_reg - cycle_inc;
   assign timeout_hit = !acr.audio_strobe && rate_ok && (state_reg != LOST) &&
                        (timeout_cnt_reg == TO_LAST);

   always_comb begin
      state_next      = state_reg;
      rate_next       = rate_reg;
      strobe_cnt_next = strobe_cnt_reg;
      cycle_cnt_next  = cycle_cnt_reg;
      stable_cnt_next = stable_cnt_reg;
      cts_next        = cts_reg;
      n_pkt_next      = n_pkt_reg;
      valid_next      = valid_reg && !acr.packet_ready;
      lost_next       = lost_reg;
      if (acr.audio_strobe || !rate_ok || state_reg == LOST || timeout_hit)
         timeout_cnt_next = '0;
      else
         timeout_cnt_next = timeout_cnt_reg + TO_W'(1);

      if (acr.rate_sel != rate_reg) begin
         rate_next        = acr.rate_sel;
         state_next       = SYNC;
         strobe_cnt_next  = '0;
         cycle_cnt_next   = '0;
         timeout_cnt_next = '0;
         stable_cnt_next  = '0;
         valid_next       = 1'b0;
         lost_next        = 1'b0;
      end else begin
         case (state_reg)
            SYNC: begin
               valid_next = 1'b0;
               if (acr.audio_strobe && rate_ok) begin
                  state_next      = MEASURE;
                  strobe_cnt_next = '0;
                  cycle_cnt_next  = '0;
               end else if (timeout_hit) begin
                  state_next      = LOST;
                  lost_next       = 1'b1;
                  stable_cnt_next = '0;
               end
            end
            MEASURE: begin
               cycle_cnt_next = cycle_inc;
               if (acr.audio_strobe) begin
                  if (strobe_cnt_reg == w_cur - 8'd1) begin
                     strobe_cnt_next = '0;
                     cycle_cnt_next  = '0;
                     cts_next        = cycle_inc;
                     n_pkt_next      = n_cur;
                     valid_next      = 1'b1;
                     if (cts_diff <= TOL)
                        stable_cnt_next = (stable_cnt_reg == ST_MAX) ? ST_MAX
                                                                     : stable_cnt_reg + ST_W'(1);
                     else
                        stable_cnt_next = '0;
                  end else begin
                     strobe_cnt_next = strobe_cnt_reg + 8'd1;
                  end
               end else if (timeout_hit) begin
                  state_next      = LOST;
                  lost_next       = 1'b1;
                  stable_cnt_next = '0;
                  valid_next      = 1'b0;
                  strobe_cnt_next = '0;
                  cycle_cnt_next  = '0;
               end
            end
            LOST: begin
               valid_next = 1'b0;
               // The recovering strobe doubles as the start strobe of a fresh window.
               if (acr.audio_strobe) begin
                  lost_next       = 1'b0;
                  state_next      = rate_ok ? MEASURE : SYNC;
                  strobe_cnt_next = '0;
                  cycle_cnt_next  = '0;
               end
            end
            default: state_next = SYNC;
         endcase
      end
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         state_reg       <= SYNC;
         rate_reg        <= acr.rate_sel;
         strobe_cnt_reg  <= '0;
         cycle_cnt_reg   <= '0;
         timeout_cnt_reg <= '0;
         stable_cnt_reg  <= '0;
         cts_reg         <= '0;
         n_pkt_reg       <= '0;
         valid_reg       <= 1'b0;
         lost_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         rate_reg        <= rate_next;
         strobe_cnt_reg  <= strobe_cnt_next;
         cycle_cnt_reg   <= cycle_cnt_next;
         timeout_cnt_reg <= timeout_cnt_next;
         stable_cnt_reg  <= stable_cnt_next;
         cts_reg         <= cts_next;
         n_pkt_reg       <= n_pkt_next;
         valid_reg       <= valid_next;
         lost_reg        <= lost_next;
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sub
         assign sub_w[gi] = {n_pkt_reg[7:0], n_pkt_reg[15:8], 4'd0, n_pkt_reg[19:16],
                             cts_reg[7:0], cts_reg[15:8], 4'd0, cts_reg[19:16], 8'd0};
      end
   endgenerate

   assign acr.sub          = sub_w;
   assign acr.header       = 24'h000001;
   assign acr.cts          = cts_reg;
   assign acr.packet_valid = valid_reg;
   assign acr.cts_locked   = (stable_cnt_reg >= ST_MAX);
   assign acr.audio_lost   = lost_reg;
endmodule

// File: tb/tb_acr_packet_generator.sv
// Directed and randomized stimulus for acr_packet_generator against a
// timestamp-based reference model of the ACR packet rules.
module tb_acr_packet_generator;
   localparam int TOUT  = 8192;
   localparam int TOL   = 2;
   localparam int LOCKN = 4;
   localparam int P_WAIT = 0, P_MEAS = 1, P_LOST = 2;

   logic clk_pixel = 1'b0;
   logic reset;
   acr_packet_generator_if bus ();

   acr_packet_generator #(
      .CTS_TOL(TOL), .LOCK_COUNT(LOCKN), .TIMEOUT_CYCLES(TOUT)
   ) dut (
      .clk_pixel(clk_pixel),
      .reset(reset),
      .acr(bus)
   );

   always #5 clk_pixel = ~clk_pixel;

   int     checks = 0;
   int     failures = 0;
   int     status_err = 0;
   string  first_bad = "";
   int     pkts = 0;
   longint cyc = 0;

   // Reference model: window timing from strobe timestamps, lock from boundary history.
   int          m_phase;
   int          m_rate;
   int          m_strobes;
   longint      m_anchor;
   longint      m_last_act;
   logic        m_valid, m_lost, m_boundary;
   logic [19:0] m_cts, m_n;
   bit          stab_q[$];

   function automatic int n_of(input int r);
      int tbl [7] = '{4096, 6272, 6144, 12544, 12288, 25088, 24576};
      if (r < 0 || r > 6) return 0;
      return tbl[r];
   endfunction

   function automatic logic [55:0] exp_sub(input logic [19:0] n, input logic [19:0] c);
      logic [55:0] v;
      v = '0;
      v |= 56'(n & 20'hFF) << 48;
      v |= 56'((n >> 8) & 20'hFF) << 40;
      v |= 56'(n >> 16) << 32;
      v |= 56'(c & 20'hFF) << 24;
      v |= 56'((c >> 8) & 20'hFF) << 16;
      v |= 56'(c >> 16) << 8;
      return v;
   endfunction

   function automatic bit model_locked();
      int run = 0;
      for (int i = stab_q.size() - 1; i >= 0; i--) begin
         if (!stab_q[i]) break;
         run++;
      end
      return run >= LOCKN;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = P_WAIT;  m_rate = int'(bus.rate_sel);
      m_strobes = 0;     m_anchor = cyc;  m_last_act = cyc;
      m_valid = 1'b0;    m_lost = 1'b0;   m_boundary = 1'b0;
      m_cts = '0;        m_n = '0;
      stab_q.delete();
   endtask

   task automatic model_edge(input logic s, input logic r, input logic [2:0] rs);
      logic   accepted;
      longint d;
      longint a;
      accepted   = m_valid && r;
      m_boundary = 1'b0;
      if (int'(rs) != m_rate) begin
         m_rate = int'(rs); m_phase = P_WAIT; m_valid = 1'b0; m_lost = 1'b0;
         stab_q.delete(); m_last_act = cyc;
      end else if (m_rate == 7) begin
         m_last_act = cyc; m_valid = 1'b0;
      end else if (s) begin
         m_last_act = cyc;
         if (m_phase != P_MEAS) begin
            m_phase = P_MEAS; m_lost = 1'b0; m_strobes = 0; m_anchor = cyc;
         end else begin
            m_strobes++;
            if (m_strobes == n_of(m_rate) / 128) begin
               d = cyc - m_anchor;
               if (d > 64'hFFFFF) d = 64'hFFFFF;
               a = d - longint'(m_cts);
               if (a < 0) a = -a;
               stab_q.push_back(a <= TOL);
               m_cts = 20'(d); m_n = 20'(n_of(m_rate));
               m_anchor = cyc; m_strobes = 0; m_valid = 1'b1; m_boundary = 1'b1;
            end else if (accepted) begin
               m_valid = 1'b0;
            end
         end
      end else if (m_phase != P_LOST && cyc - m_last_act == TOUT) begin
         m_phase = P_LOST; m_lost = 1'b1; m_valid = 1'b0; stab_q.delete();
      end else if (accepted) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic tick();
      logic s, r;
      logic [2:0] rs;
      logic [22:0] got_st, exp_st;
      s = bus.audio_strobe; r = bus.packet_ready; rs = bus.rate_sel;
      @(posedge clk_pixel);
      #1;
      cyc++;
      model_edge(s, r, rs);
      exp_st = {m_valid, m_lost, model_locked(), m_cts};
      got_st = {bus.packet_valid, bus.audio_lost, bus.cts_locked, bus.cts};
      if (got_st !== exp_st) begin
         status_err++;
         if (first_bad == "")
            first_bad = $sformatf("cyc=%0d {valid,lost,locked,cts} got=%0h exp=%0h",
                                  cyc, got_st, exp_st);
      end
      if (m_boundary) begin
         pkts++;
         $display("pkt %0d cyc=%0d rate=%0d cts=%0d valid=%0b locked=%0b",
                  pkts, cyc, m_rate, bus.cts, bus.packet_valid, bus.cts_locked);
         for (int i = 0; i < 4; i++)
            check($sformatf("sub%0d_at_boundary", i), 64'(bus.sub[i]), 64'(exp_sub(m_n, m_cts)));
      end
   endtask

   task automatic strobes(input int count, input int period);
      for (int k = 0; k < count; k++) begin
         for (int j = 1; j < period; j++) tick();
         bus.audio_strobe = 1'b1;
         tick();
         bus.audio_strobe = 1'b0;
      end
   endtask

   task automatic check_status(input string tag);
      if (status_err != 0) $display("first divergence (%s): %s", tag, first_bad);
      check(tag, 64'(status_err), 64'd0);
      status_err = 0;
      first_bad  = "";
   endtask

   initial begin
      int rate, nwin, per;
      logic [55:0] s0;

      reset = 1'b1;
      bus.audio_strobe = 1'b0;
      bus.rate_sel     = 3'd2;
      bus.packet_ready = 1'b1;
      @(posedge clk_pixel);
      @(posedge clk_pixel);
      #1;
      reset = 1'b0;
      model_reset();
      check("reset_valid",  64'(bus.packet_valid), 64'd0);
      check("reset_lost",   64'(bus.audio_lost),   64'd0);
      check("reset_locked", 64'(bus.cts_locked),   64'd0);
      check("reset_cts",    64'(bus.cts),          64'd0);
      check("reset_sub0",   64'(bus.sub[0]),       64'd0);
      check("header",       64'(bus.header),       64'h000001);

      // First window at 48 kHz, 525 cycles per strobe
      strobes(48, 525);
      check("no_packet_partial", 64'(bus.packet_valid), 64'd0);
      strobes(1, 525);
      s0 = bus.sub[0];
      check("first_valid", 64'(bus.packet_valid), 64'd1);
      check("first_cts",   64'(bus.cts),          64'd25200);
      check("first_n_bytes", 64'(s0[55:32]),      64'h001800);
      check_status("status_first_window");

      // Lock after four stable windows, lost on jitter
      strobes(192, 20);
      check("locked_after_3_stable", 64'(bus.cts_locked), 64'd0);
      strobes(48, 20);
      check("locked_after_4_stable", 64'(bus.cts_locked), 64'd1);
      check("stable_cts", 64'(bus.cts), 64'd960);
      strobes(47, 20);
      strobes(1, 30);
      check("jitter_cts",    64'(bus.cts),        64'd970);
      check("jitter_unlock", 64'(bus.cts_locked), 64'd0);
      check_status("status_lock");

      // Scheduler stalled over three windows: newest contents overwrite
      bus.packet_ready = 1'b0;
      strobes(96, 20);
      strobes(48, 21);
      check("held_valid", 64'(bus.packet_valid), 64'd1);
      check("held_cts",   64'(bus.cts),          64'd1008);
      check("held_sub1",  64'(bus.sub[1]),       64'(exp_sub(20'd6144, 20'd1008)));
      bus.packet_ready = 1'b1;
      tick();
      check("accept_drop", 64'(bus.packet_valid), 64'd0);
      tick();
      check("accept_once", 64'(bus.packet_valid), 64'd0);
      check_status("status_stall");

      // Audio loss exactly TOUT cycles after the last strobe
      while (cyc < m_last_act + TOUT - 1) tick();
      check("lost_not_yet", 64'(bus.audio_lost), 64'd0);
      tick();
      check("lost_set",    64'(bus.audio_lost),   64'd1);
      check("lost_valid",  64'(bus.packet_valid), 64'd0);
      check("lost_locked", 64'(bus.cts_locked),   64'd0);
      check("lost_cts",    64'(bus.cts),          64'd1008);
      strobes(1, 20);
      check("lost_cleared", 64'(bus.audio_lost), 64'd0);
      strobes(47, 20);
      check("resume_no_packet", 64'(bus.packet_valid), 64'd0);
      strobes(1, 20);
      check("resume_valid", 64'(bus.packet_valid), 64'd1);
      check("resume_cts",   64'(bus.cts),          64'd960);
      check_status("status_lost");

      // Rate switch 48k -> 32k mid-window with a locked, pending packet
      bus.packet_ready = 1'b0;
      strobes(192, 20);
      check("pre_switch_locked", 64'(bus.cts_locked),   64'd1);
      check("pre_switch_valid",  64'(bus.packet_valid), 64'd1);
      strobes(10, 20);
      bus.rate_sel = 3'd0;
      tick();
      check("switch_valid",  64'(bus.packet_valid), 64'd0);
      check("switch_locked", 64'(bus.cts_locked),   64'd0);
      bus.packet_ready = 1'b1;
      strobes(32, 20);
      check("switch_no_packet", 64'(bus.packet_valid), 64'd0);
      strobes(1, 20);
      s0 = bus.sub[0];
      check("switch_valid_new", 64'(bus.packet_valid), 64'd1);
      check("switch_cts",       64'(bus.cts),          64'd640);
      check("switch_n_bytes",   64'(s0[55:32]),        64'h001000);
      check_status("status_switch");

      // Reserved rate: never produces a packet
      bus.rate_sel = 3'd7;
      strobes(40, 10);
      check("reserved_valid", 64'(bus.packet_valid), 64'd0);
      check_status("status_reserved");

      // Random rates, periods and scheduler readiness
      for (int round = 0; round < 4; round++) begin
         rate = int'($urandom_range(0, 6));
         bus.rate_sel = 3'(rate);
         nwin = n_of(rate) / 128;
         nwin = nwin + 1 + int'($urandom_range(0, nwin));
         for (int k = 0; k < nwin; k++) begin
            per = int'($urandom_range(4, 12));
            bus.packet_ready = 1'($urandom_range(0, 1));
            strobes(1, per);
         end
         check_status($sformatf("status_random%0d", round));
      end

      // Asynchronous reset while a packet is pending
      bus.packet_ready = 1'b0;
      bus.rate_sel = 3'd7;
      tick();
      bus.rate_sel = 3'd2;
      strobes(49, 20);
      check("prereset_valid", 64'(bus.packet_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check("async_valid", 64'(bus.packet_valid), 64'd0);
      check("async_cts",   64'(bus.cts),          64'd0);
      check("async_sub2",  64'(bus.sub[2]),       64'd0);
      check("async_lost",  64'(bus.audio_lost),   64'd0);
      @(posedge clk_pixel);
      #1;
      reset = 1'b0;
      model_reset();
      bus.packet_ready = 1'b1;
      strobes(49, 20);
      check("post_reset_cts", 64'(bus.cts), 64'd960);
      check_status("status_post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/acr_packet_generator.md
ACR_PACKET_GENERATOR -- requirements
Module: acr_packet_generator

Interface
REQ-001 SHALL have parameter CTS_TOL, default 2, max |CTS delta| between consecutive windows still counted as stable.
REQ-002 SHALL have parameter LOCK_COUNT, default 4, consecutive stable windows required to assert cts_locked.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536, clk_pixel cycles without audio_strobe before audio loss is declared.
REQ-004 clk_pixel  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 audio_strobe  input  1  single-cycle pulse per audio sample (fs), synchronous to clk_pixel.
REQ-007 rate_sel  input  3  0:32k 1:44.1k 2:48k 3:88.2k 4:96k 5:176.4k 6:192k 7:reserved.
REQ-008 packet_ready  input  1  packet scheduler accepts the current packet.
REQ-009 packet_valid  output  1  ACR packet available.
REQ-010 header  output  24  packet header.
REQ-011 sub  output  4x56  four subpackets.
REQ-012 cts  output  20  last published CTS.
REQ-013 cts_locked  output  1  CTS stable.
REQ-014 audio_lost  output  1  audio strobe timeout active.

Function
REQ-015 N from rate_sel SHALL be 4096, 6272, 6144, 12544, 12288, 25088, 24576 for codes 0-6; window length W = N/128 strobes (32, 49, 48, 98, 96, 196, 192).
REQ-016 FSM SHALL have states SYNC (discard partial window), MEASURE, LOST.
REQ-017 SYNC: at the first strobe entered in SYNC, SHALL clear strobe count and cycle count and go to MEASURE; no packet from that partial interval.
REQ-018 MEASURE: 8-bit strobe counter increments per strobe; the W-th strobe SHALL be a window boundary and reset the counter to 0.
REQ-019 Cycle counter SHALL count clk_pixel cycles from the cycle after one boundary through the next boundary cycle inclusive, saturating at 20'hFFFFF.
REQ-020 At each boundary: cts <= cycle count, sub reloaded, packet_valid <= 1, cycle counter restarts at 1 on the following cycle.
REQ-021 sub[i] SHALL equal, for all i, {N[7:0], N[15:8], 4'd0, N[19:16], cts[7:0], cts[15:8], 4'd0, cts[19:16], 8'd0}.
REQ-022 header SHALL be the constant {8'd0, 8'd0, 8'd1}.
REQ-023 packet_valid SHALL stay high with sub stable until packet_valid && packet_ready, then drop next cycle.
REQ-024 Boundary coinciding with acceptance: current packet accepted, new contents loaded, packet_valid stays 1.
REQ-025 Boundary while packet unaccepted: contents overwritten with newest, packet_valid stays 1 (no queueing).
REQ-026 Stability: boundary with |new - previous cts| <= CTS_TOL increments stable count (saturating); otherwise clears it; cts_locked = stable count >= LOCK_COUNT.
REQ-027 rate_sel change (vs. registered copy) SHALL, next cycle: go to SYNC, clear counters, stable count, cts_locked, packet_valid.
REQ-028 rate_sel = 7 SHALL hold the FSM in SYNC, packet_valid 0.
REQ-029 TIMEOUT_CYCLES cycles without a strobe in SYNC or MEASURE SHALL enter LOST: audio_lost 1, cts_locked 0, packet_valid 0, counters cleared; cts retains its last value.
REQ-030 LOST: next strobe clears audio_lost and enters SYNC, that strobe acting as the SYNC start strobe.
REQ-031 Strobe and timeout on the same cycle: strobe wins, timeout counter cleared.

Reset
REQ-032 Reset SHALL force state SYNC; packet_valid, cts_locked, audio_lost 0; cts 0; sub all 0; all counters 0; registered rate_sel = rate_sel input.
REQ-033 Reset mid-packet SHALL drop packet_valid immediately (asynchronously) with no acceptance.

Verification
REQ-034 rate_sel=2, strobe every 525 cycles, ready=1 -> first packet after 1 discard + 48 strobes; cts=25200; sub[0][55:32]=24'h001800 (bytes 00,18,00).
REQ-035 Same stimulus, 4 further windows -> cts_locked rises at the 4th stable boundary; jitter one window to 25210 -> cts_locked falls.
REQ-036 packet_ready=0 for 3 windows -> packet_valid held, sub shows latest cts; ready=1 -> single acceptance, valid drops.
REQ-037 Stop strobes -> audio_lost=1 exactly 65536 cycles after last strobe, valid=0, locked=0; resume -> audio_lost clears on first strobe, first packet after 1+48 strobes.
REQ-038 Switch rate_sel 2->0 mid-window -> valid and locked cleared next cycle; next packet after 1+32 strobes with N=4096.
REQ-039 Assert reset while packet_valid=1 -> all outputs at reset values the same cycle.
